// File: rtl/valid_flush_ctrl_pkg.sv
// Shared state encodings and constants for the cache valid-bit controller.
// Imported by the controller top and its interface users.
package valid_flush_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int DRAIN_LEN = 2;

endpackage

// File: rtl/valid_flush_ctrl_if.sv
// Client-side bundle of the valid-bit controller: A/B writers, reader, flush.
// master = cache clients, slave = controller.
interface valid_flush_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int DEEPTH = 8
);

  logic              a_req;
  logic [DEEPTH-1:0] a_addr;
  logic [WIDTH-1:0]  a_data;
  logic              a_ready;
  logic              b_req;
  logic [DEEPTH-1:0] b_addr;
  logic [WIDTH-1:0]  b_data;
  logic              b_ready;
  logic              rd_req;
  logic [DEEPTH-1:0] rd_addr;
  logic              rd_ready;
  logic              rd_valid;
  logic [WIDTH-1:0]  rd_data;
  logic              flush_req;
  logic              flush_busy;
  logic              flush_done;

  modport master (
    output a_req, a_addr, a_data,
    output b_req, b_addr, b_data,
    output rd_req, rd_addr, flush_req,
    input  a_ready, b_ready, rd_ready,
    input  rd_valid, rd_data,
    input  flush_busy, flush_done
  );

  modport slave (
    input  a_req, a_addr, a_data,
    input  b_req, b_addr, b_data,
    input  rd_req, rd_addr, flush_req,
    output a_ready, b_ready, rd_ready,
    output rd_valid, rd_data,
    output flush_busy, flush_done
  );

endinterface

// File: rtl/valid_flush_ctrl_sweep_cnt.sv
// Flush sweep counter: one count per pair of lines, with clear,
// enable and a flag raised on the final count.
module flush_sweep_cnt #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == W'(N - 1));

endmodule

// File: rtl/valid_flush_ctrl.sv
// Valid-bit RAM controller: A/B write arbitration, read return, flush sweep.
// VCTRL_RESET_FLUSH_EN: when defined, a flush runs straight out of reset.
module valid_flush_ctrl
  import valid_flush_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  valid_flush_ctrl_if.slave bus,
  output logic              ram_W_en_A,
  output logic [DEEPTH-1:0] ram_W_addr_A,
  output logic [WIDTH-1:0]  ram_W_data_A,
  output logic              ram_W_en_B,
  output logic [DEEPTH-1:0] ram_W_addr_B,
  output logic [WIDTH-1:0]  ram_W_data_B,
  output logic              ram_R_en_A,
  output logic [DEEPTH-1:0] ram_R_addr_A,
  input  logic [WIDTH-1:0]  ram_R_data_A
);

  localparam int CW     = (DEEPTH > 1) ? DEEPTH - 1 : 1;
  localparam int NSWEEP = 2 ** (DEEPTH - 1);

`ifdef VCTRL_RESET_FLUSH_EN
  localparam state_t RST_STATE = S_FLUSH;
  localparam logic   RST_BUSY  = 1'b1;
`else
  localparam state_t RST_STATE = S_IDLE;
  localparam logic   RST_BUSY  = 1'b0;
`endif

  state_t r_state;
  state_t w_nxt;
  logic   r_busy;
  logic   r_done;
  logic   w_done_nxt;
  logic   r_drain;

  logic          w_in_flush;
  logic          w_fl;
  logic [CW-1:0] w_cnt;
  logic          w_last;

  logic w_open;
  logic w_conf;
  logic w_a_acc;
  logic w_b_acc;
  logic w_rd_acc;

  flush_sweep_cnt #(
    .W (CW),
    .N (NSWEEP)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (!w_in_flush),
    .i_en   (w_in_flush),
    .o_cnt  (w_cnt),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RST_STATE;
      r_busy  <= RST_BUSY;
      r_done  <= 1'b0;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= (w_nxt != S_IDLE);
      r_done  <= w_done_nxt;
      r_drain <= (r_state == S_DRAIN) ? r_drain + 1'b1 : 1'b0;
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_done_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.flush_req) begin
          w_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (w_last) begin
          w_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain == 1'(DRAIN_LEN - 1)) begin
          w_nxt      = S_IDLE;
          w_done_nxt = 1'b1;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // rst_n gating keeps readies and RAM enables quiet while reset is held
  assign w_in_flush = (r_state == S_FLUSH);
  assign w_fl       = w_in_flush & rst_n;
  assign w_open     = rst_n & (r_state == S_IDLE) & !bus.flush_req;
  assign w_conf     = bus.a_req & bus.b_req
                    & (bus.a_addr == bus.b_addr);
  assign w_a_acc    = w_open & bus.a_req;
  assign w_b_acc    = w_open & bus.b_req & !w_conf;
  assign w_rd_acc   = w_open & bus.rd_req;

  assign bus.a_ready    = w_a_acc;
  assign bus.b_ready    = w_b_acc;
  assign bus.rd_ready   = w_rd_acc;
  assign bus.flush_busy = r_busy;
  assign bus.flush_done = r_done;

  assign ram_W_en_A   = w_fl | w_a_acc;
  assign ram_W_addr_A = w_fl ? DEEPTH'({w_cnt, 1'b0}) : bus.a_addr;
  assign ram_W_data_A = w_fl ? '0 : bus.a_data;
  assign ram_W_en_B   = w_fl | w_b_acc;
  assign ram_W_addr_B = w_fl ? DEEPTH'({w_cnt, 1'b1}) : bus.b_addr;
  assign ram_W_data_B = w_fl ? '0 : bus.b_data;
  assign ram_R_en_A   = w_rd_acc;
  assign ram_R_addr_A = bus.rd_addr;

  // The RAM takes two cycles to commit a write, so writes from this
  // cycle and the previous two are forwarded over the RAM read data.
  logic [1:0]        w_cur_en;
  logic [DEEPTH-1:0] w_cur_addr [2];
  logic [WIDTH-1:0]  w_cur_data [2];
  logic [1:0]        r_h1_en;
  logic [DEEPTH-1:0] r_h1_addr  [2];
  logic [WIDTH-1:0]  r_h1_data  [2];
  logic [1:0]        r_h2_en;
  logic [DEEPTH-1:0] r_h2_addr  [2];
  logic [WIDTH-1:0]  r_h2_data  [2];

  assign w_cur_en      = {ram_W_en_B, ram_W_en_A};
  assign w_cur_addr[0] = ram_W_addr_A;
  assign w_cur_addr[1] = ram_W_addr_B;
  assign w_cur_data[0] = ram_W_data_A;
  assign w_cur_data[1] = ram_W_data_B;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h1_en <= '0;
      r_h2_en <= '0;
      for (int p = 0; p < 2; p++) begin
        r_h1_addr[p] <= '0;
        r_h1_data[p] <= '0;
        r_h2_addr[p] <= '0;
        r_h2_data[p] <= '0;
      end
    end else begin
      r_h1_en <= w_cur_en;
      r_h2_en <= r_h1_en;
      for (int p = 0; p < 2; p++) begin
        r_h1_addr[p] <= w_cur_addr[p];
        r_h1_data[p] <= w_cur_data[p];
        r_h2_addr[p] <= r_h1_addr[p];
        r_h2_data[p] <= r_h1_data[p];
      end
    end
  end

  logic             w_hit;
  logic [WIDTH-1:0] w_fdata;

  always_comb begin
    w_hit   = 1'b0;
    w_fdata = '0;
    for (int p = 0; p < 2; p++) begin
      if (r_h2_en[p] && (r_h2_addr[p] == bus.rd_addr)) begin
        w_hit   = 1'b1;
        w_fdata = r_h2_data[p];
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (r_h1_en[p] && (r_h1_addr[p] == bus.rd_addr)) begin
        w_hit   = 1'b1;
        w_fdata = r_h1_data[p];
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (w_cur_en[p] && (w_cur_addr[p] == bus.rd_addr)) begin
        w_hit   = 1'b1;
        w_fdata = w_cur_data[p];
      end
    end
  end

  logic             r_rd_valid;
  logic             r_fwd_hit;
  logic [WIDTH-1:0] r_fwd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_fwd_hit  <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_rd_valid <= w_rd_acc;
      r_fwd_hit  <= w_rd_acc & w_hit;
      r_fwd_data <= w_fdata;
    end
  end

  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = !r_rd_valid ? '0
                      : r_fwd_hit  ? r_fwd_data
                      : ram_R_data_A;

endmodule

// File: tb/tb_valid_flush_ctrl.sv
// Directed bench for valid_flush_ctrl with a two-cycle-write RAM model.
// Expectations follow VCTRL_RESET_FLUSH_EN when it is defined.
module tb_valid_flush_ctrl;

  localparam int W = 4;
  localparam int D = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  valid_flush_ctrl_if #(.WIDTH(W), .DEEPTH(D)) bus ();

  logic         ram_W_en_A;
  logic [D-1:0] ram_W_addr_A;
  logic [W-1:0] ram_W_data_A;
  logic         ram_W_en_B;
  logic [D-1:0] ram_W_addr_B;
  logic [W-1:0] ram_W_data_B;
  logic         ram_R_en_A;
  logic [D-1:0] ram_R_addr_A;
  logic [W-1:0] ram_R_data_A = '0;

  valid_flush_ctrl #(.WIDTH(W), .DEEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .ram_W_en_A   (ram_W_en_A),
    .ram_W_addr_A (ram_W_addr_A),
    .ram_W_data_A (ram_W_data_A),
    .ram_W_en_B   (ram_W_en_B),
    .ram_W_addr_B (ram_W_addr_B),
    .ram_W_data_B (ram_W_data_B),
    .ram_R_en_A   (ram_R_en_A),
    .ram_R_addr_A (ram_R_addr_A),
    .ram_R_data_A (ram_R_data_A)
  );

  // RAM model: writes land in the array one cycle after capture
  logic [W-1:0] mem [8];
  logic         s_ea = 1'b0;
  logic         s_eb = 1'b0;
  logic [D-1:0] s_aa = '0;
  logic [D-1:0] s_ab = '0;
  logic [W-1:0] s_da = '0;
  logic [W-1:0] s_db = '0;

  always @(posedge clk) begin
    s_ea <= ram_W_en_A;
    s_aa <= ram_W_addr_A;
    s_da <= ram_W_data_A;
    s_eb <= ram_W_en_B;
    s_ab <= ram_W_addr_B;
    s_db <= ram_W_data_B;
    if (s_ea) mem[s_aa] <= s_da;
    if (s_eb) mem[s_ab] <= s_db;
    if (ram_R_en_A) ram_R_data_A <= mem[ram_R_addr_A];
  end

  int errors = 0;
  int checks = 0;

`ifdef VCTRL_RESET_FLUSH_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.a_req     = 1'b0;
    bus.a_addr    = '0;
    bus.a_data    = '0;
    bus.b_req     = 1'b0;
    bus.b_addr    = '0;
    bus.b_data    = '0;
    bus.rd_req    = 1'b0;
    bus.rd_addr   = '0;
    bus.flush_req = 1'b0;
  endtask

  task automatic drive_wr(input logic ae, input logic [D-1:0] aa,
                          input logic [W-1:0] ad, input logic be,
                          input logic [D-1:0] ba,
                          input logic [W-1:0] bd);
    bus.a_req  = ae;
    bus.a_addr = aa;
    bus.a_data = ad;
    bus.b_req  = be;
    bus.b_addr = ba;
    bus.b_data = bd;
    cyc();
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
  endtask

  task automatic rd(input logic [D-1:0] addr, output logic v,
                    output logic [W-1:0] d);
    bus.rd_req  = 1'b1;
    bus.rd_addr = addr;
    cyc();
    bus.rd_req = 1'b0;
    @(negedge clk);
    v = bus.rd_valid;
    d = bus.rd_data;
    cyc();
  endtask

  // With auto-flush the sweep after release is checked as a full flush
  task automatic watch_auto_flush(input string tag);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.flush_busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_busy[%0d]: got %b want 1", tag, k, bus.flush_busy);
      end
      if (k < 4) begin
        checks++;
        if (ram_W_addr_A !== 3'(2 * k) || ram_W_en_A !== 1'b1) begin
          errors++;
          $display("FAIL %s_addrA[%0d]: got en=%b a=%0d want en=1 a=%0d",
                   tag, k, ram_W_en_A, ram_W_addr_A, 2 * k);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (bus.flush_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: got %b want 1", tag, bus.flush_done);
    end
    cyc();
  endtask

  task automatic test_reset();
    clr_in();
    bus.a_req  = 1'b1;
    bus.b_req  = 1'b1;
    bus.b_addr = 3'd1;
    bus.rd_req = 1'b1;
    #12;
    checks++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0 || bus.rd_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready: got a=%b b=%b r=%b want 0 0 0",
               bus.a_ready, bus.b_ready, bus.rd_ready);
    end
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.flush_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid_done: got %b %b want 0 0", bus.rd_valid, bus.flush_done);
    end
    checks++;
    if (bus.flush_busy !== BUSY_RST) begin
      errors++;
      $display("FAIL rst_busy: got %b want %b", bus.flush_busy, BUSY_RST);
    end
    checks++;
    if (ram_W_en_A !== 1'b0 || ram_W_en_B !== 1'b0 || ram_R_en_A !== 1'b0) begin
      errors++;
      $display("FAIL rst_ram_en: got %b %b %b want 0 0 0",
               ram_W_en_A, ram_W_en_B, ram_R_en_A);
    end
    clr_in();
    cyc();
    rst_n = 1'b1;
`ifdef VCTRL_RESET_FLUSH_EN
    watch_auto_flush("rst_auto");
`else
    @(negedge clk);
    checks++;
    if (bus.flush_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle_busy: got %b want 0", bus.flush_busy);
    end
    cyc();
`endif
  endtask

  task automatic test_basic();
    logic v;
    logic [W-1:0] d;
    drive_wr(1'b1, 3'd5, 4'hA, 1'b0, 3'd0, 4'h0);
    rd(3'd5, v, d);
    checks++;
    if (v !== 1'b1 || d !== 4'hA) begin
      errors++;
      $display("FAIL basic_rd: got v=%b d=%h want v=1 d=a", v, d);
    end
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_valid_drop: got %b want 0", bus.rd_valid);
    end
    cyc();
  endtask

  task automatic test_conflict();
    logic v;
    logic [W-1:0] d;
    bus.a_req  = 1'b1;
    bus.a_addr = 3'd2;
    bus.a_data = 4'h3;
    bus.b_req  = 1'b1;
    bus.b_addr = 3'd2;
    bus.b_data = 4'hC;
    @(negedge clk);
    checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0 || ram_W_en_B !== 1'b0) begin
      errors++;
      $display("FAIL conf_ready: got a=%b b=%b enB=%b want 1 0 0",
               bus.a_ready, bus.b_ready, ram_W_en_B);
    end
    cyc();
    bus.a_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.b_ready !== 1'b1 || ram_W_data_B !== 4'hC) begin
      errors++;
      $display("FAIL conf_b_next: got rdy=%b data=%h want 1 c",
               bus.b_ready, ram_W_data_B);
    end
    cyc();
    bus.b_req = 1'b0;
    rd(3'd2, v, d);
    checks++;
    if (v !== 1'b1 || d !== 4'hC) begin
      errors++;
      $display("FAIL conf_rd_fwd: got v=%b d=%h want 1 c", v, d);
    end
    rd(3'd2, v, d);
    checks++;
    if (v !== 1'b1 || d !== 4'hC) begin
      errors++;
      $display("FAIL conf_rd_ram: got v=%b d=%h want 1 c", v, d);
    end
  endtask

  task automatic test_flush();
    logic v;
    logic [W-1:0] d;
    for (int i = 0; i < 4; i++) begin
      drive_wr(1'b1, 3'(2 * i), 4'hF, 1'b1, 3'(2 * i + 1), 4'hF);
    end
    bus.rd_req  = 1'b1;
    bus.rd_addr = 3'd0;
    cyc();
    bus.rd_req    = 1'b0;
    bus.flush_req = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 4'hF) begin
      errors++;
      $display("FAIL flush_pre_rd: got v=%b d=%h want 1 f", bus.rd_valid, bus.rd_data);
    end
    cyc();
    bus.flush_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.flush_busy !== 1'b1 || bus.flush_done !== 1'b0) begin
        errors++;
        $display("FAIL flush_busy[%0d]: got busy=%b done=%b want 1 0",
                 k, bus.flush_busy, bus.flush_done);
      end
      checks++;
      if (k < 4) begin
        if (ram_W_en_A !== 1'b1 || ram_W_en_B !== 1'b1 ||
            ram_W_addr_A !== 3'(2 * k) || ram_W_addr_B !== 3'(2 * k + 1) ||
            ram_W_data_A !== 4'h0 || ram_W_data_B !== 4'h0) begin
          errors++;
          $display("FAIL flush_pair[%0d]: got en=%b%b a=%0d,%0d d=%h,%h want 11 %0d,%0d 0,0",
                   k, ram_W_en_A, ram_W_en_B, ram_W_addr_A, ram_W_addr_B,
                   ram_W_data_A, ram_W_data_B, 2 * k, 2 * k + 1);
        end
      end else begin
        if (ram_W_en_A !== 1'b0 || ram_W_en_B !== 1'b0) begin
          errors++;
          $display("FAIL flush_drain_en[%0d]: got %b%b want 00", k, ram_W_en_A, ram_W_en_B);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (bus.flush_busy !== 1'b0 || bus.flush_done !== 1'b1) begin
      errors++;
      $display("FAIL flush_end: got busy=%b done=%b want 0 1", bus.flush_busy, bus.flush_done);
    end
    @(negedge clk);
    checks++;
    if (bus.flush_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_done_pulse: got %b want 0", bus.flush_done);
    end
    cyc();
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v, d);
      checks++;
      if (v !== 1'b1 || d !== 4'h0) begin
        errors++;
        $display("FAIL flush_rd[%0d]: got v=%b d=%h want 1 0", i, v, d);
      end
    end
  endtask

  task automatic test_stall();
    logic v;
    logic [W-1:0] d;
    bus.a_req     = 1'b1;
    bus.a_addr    = 3'd1;
    bus.a_data    = 4'h5;
    bus.flush_req = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.a_ready !== 1'b0 || ram_W_en_A !== 1'b0) begin
      errors++;
      $display("FAIL stall_start: got rdy=%b en=%b want 0 0", bus.a_ready, ram_W_en_A);
    end
    cyc();
    bus.flush_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.a_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready[%0d]: got %b want 0", k, bus.a_ready);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.flush_done !== 1'b1 || bus.a_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_accept: got done=%b rdy=%b want 1 1", bus.flush_done, bus.a_ready);
    end
    cyc();
    bus.a_req = 1'b0;
    rd(3'd1, v, d);
    checks++;
    if (v !== 1'b1 || d !== 4'h5) begin
      errors++;
      $display("FAIL stall_rd_fwd: got v=%b d=%h want 1 5", v, d);
    end
    cyc();
    cyc();
    rd(3'd1, v, d);
    checks++;
    if (v !== 1'b1 || d !== 4'h5) begin
      errors++;
      $display("FAIL stall_rd_ram: got v=%b d=%h want 1 5", v, d);
    end
  endtask

  task automatic test_reset_mid();
    bus.flush_req = 1'b1;
    cyc();
    bus.flush_req = 1'b0;
    bus.a_req     = 1'b1;
    bus.a_addr    = 3'd3;
    bus.a_data    = 4'h7;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ram_W_addr_A !== 3'd4 || ram_W_en_A !== 1'b1) begin
      errors++;
      $display("FAIL mid_c2: got en=%b a=%0d want 1 4", ram_W_en_A, ram_W_addr_A);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.flush_busy !== BUSY_RST || bus.flush_done !== 1'b0 ||
        bus.rd_valid !== 1'b0 || bus.a_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_out: got busy=%b done=%b v=%b rdy=%b want %b 0 0 0",
               bus.flush_busy, bus.flush_done, bus.rd_valid, bus.a_ready, BUSY_RST);
    end
    checks++;
    if (ram_W_en_A !== 1'b0 || ram_W_en_B !== 1'b0 || ram_R_en_A !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_en: got %b %b %b want 0 0 0", ram_W_en_A, ram_W_en_B, ram_R_en_A);
    end
    bus.a_req = 1'b0;
    cyc();
    rst_n = 1'b1;
`ifdef VCTRL_RESET_FLUSH_EN
    watch_auto_flush("mid_auto");
`else
    @(negedge clk);
    checks++;
    if (bus.flush_busy !== 1'b0 || ram_W_en_A !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle: got busy=%b en=%b want 0 0", bus.flush_busy, ram_W_en_A);
    end
    cyc();
`endif
  endtask

  task automatic test_rw_same();
    bus.rd_req  = 1'b1;
    bus.rd_addr = 3'd6;
    bus.b_req   = 1'b1;
    bus.b_addr  = 3'd6;
    bus.b_data  = 4'h9;
    @(negedge clk);
    checks++;
    if (bus.rd_ready !== 1'b1 || bus.b_ready !== 1'b1) begin
      errors++;
      $display("FAIL rw_ready: got r=%b b=%b want 1 1", bus.rd_ready, bus.b_ready);
    end
    cyc();
    clr_in();
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 4'h9) begin
      errors++;
      $display("FAIL rw_data: got v=%b d=%h want 1 9", bus.rd_valid, bus.rd_data);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_conflict();
    test_flush();
    test_stall();
    test_reset_mid();
    test_rw_same();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
